cell_editor: RTL and testbench
==============================

CELL_EDITOR -- requirements
Module: cell_editor

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4: consecutive stable ticks before a button state is accepted.
REQ-002 SHALL have parameter RPT_DELAY, default 32: held ticks before auto-repeat starts.
REQ-003 SHALL have parameter RPT_RATE, default 8: ticks between auto-repeat pulses.
REQ-004 SHALL have parameter BLINK_TICKS, default 16: ticks per cursor_blink half-period.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port tick, input, 1: one-cycle sample strobe, about 190 Hz.
REQ-008 SHALL have port edit_en, input, 1: editing allowed while the game is paused.
REQ-009 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_toggle, input, 1 each: raw buttons, active-high.
REQ-010 SHALL have ports cur_row, output, 5, and cur_col, output, 5: cursor position (rows 0..23, cols 0..31).
REQ-011 SHALL have port cell_rd, input, 1: current board value at (cur_row, cur_col), valid in the same cycle.
REQ-012 SHALL have ports wr_valid, output, 1, and wr_ready, input, 1: the write handshake.
REQ-013 SHALL have ports wr_row, output, 5, wr_col, output, 5, and wr_data, output, 1: the write payload.
REQ-014 SHALL have port cursor_blink, output, 1: overlay blink phase.

Function
REQ-015 SHALL debounce each button independently: the accepted state changes only after DEB_TICKS consecutive tick samples that all differ from it; samples are taken only on tick.
REQ-016 SHALL generate a press event on an accepted 0->1 transition.
REQ-017 SHALL generate auto-repeat events for up, down, left and right only: first repeat after RPT_DELAY held ticks, then one every RPT_RATE ticks; toggle never repeats.
REQ-018 SHALL move on a move event: down row+1, up row-1, right col+1, left col-1.
REQ-019 SHALL wrap rows 23->0 and 0->23, and columns 31->0 and 0->31.
REQ-020 SHALL apply no row change when up and down events occur in the same cycle, and no column change when left and right do; an orthogonal pair moves diagonally.
REQ-021 SHALL use FSM states IDLE, CAPTURE and WRITE.
REQ-022 SHALL go IDLE->CAPTURE on a toggle event while edit_en=1.
REQ-023 SHALL, in CAPTURE, latch wr_row/wr_col = cursor and wr_data = ~cell_rd, then go to WRITE the next cycle.
REQ-024 SHALL assert wr_valid only in WRITE and hold the payload stable until wr_valid & wr_ready, then return to IDLE the following cycle.
REQ-025 SHALL ignore all button events while not in IDLE; events are not queued.
REQ-026 SHALL ignore button events while edit_en=0, while debounce continues; a write already in CAPTURE or WRITE completes regardless of edit_en.
REQ-027 SHALL give a one-write latency of at least 2 cycles from the toggle event to wr_valid.
REQ-028 SHALL toggle cursor_blink every BLINK_TICKS ticks; cursor_blink is forced to 1 while edit_en=0.

Reset
REQ-029 SHALL, on reset_n=0 at a clk edge, set cur_row=12, cur_col=16, wr_valid=0, wr_row=0, wr_col=0, wr_data=0, cursor_blink=1 and FSM=IDLE.
REQ-030 SHALL, on reset, clear all debounce, repeat and blink counters and set every accepted button state to 0.
REQ-031 SHALL abandon a pending write on reset mid-handshake without completing it.

Structure
REQ-032 SHALL place constants BOARD_ROWS=24, BOARD_COLS=32, ROW_W=5 and COL_W=5 and the FSM state encodings in the shared conway_pkg include, used also by the board and display blocks.
REQ-033 SHALL implement debounce plus repeat as sub-module btn_conditioner, instantiated five times (repeat disabled on toggle).

Verification
REQ-034 SHALL check: bounce 1,0,1 on btn_down over 3 ticks, then steady for 4 ticks -> exactly one move, cur_row 12->13.
REQ-035 SHALL check: btn_left held 32+16 ticks from col 16 -> cur_col 15, then 14 and 13 from repeats at ticks 32 and 40; at col 0 a further left -> 31.
REQ-036 SHALL check: toggle at (12,16) with cell_rd=0 and wr_ready=0 for 5 cycles -> wr_valid high with row 12, col 16, data 1, payload stable; wr_ready=1 -> wr_valid low the next cycle.
REQ-037 SHALL check: btn_up and btn_down pressed together with btn_right -> row unchanged, col+1.
REQ-038 SHALL check: edit_en=0 with toggle pressed -> no wr_valid; edit_en dropped during WRITE -> the write still completes.
REQ-039 SHALL check: reset_n=0 during WRITE -> wr_valid=0 and cursor (12,16) the next cycle.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared constants, button indices and editor FSM encoding for the Conway board,
// display and cell editor blocks.
package conway_pkg;

  localparam int unsigned BOARD_ROWS = 24;
  localparam int unsigned BOARD_COLS = 32;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned COL_W      = 5;

  localparam int unsigned NUM_BTNS   = 5;
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_TOGGLE = 4;

  localparam logic [ROW_W-1:0] CUR_ROW_RST = ROW_W'(BOARD_ROWS / 2);
  localparam logic [COL_W-1:0] CUR_COL_RST = COL_W'(BOARD_COLS / 2);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(BOARD_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(BOARD_COLS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } editor_state_e;

  // Opposing steps in the same cycle cancel; otherwise wrap at the board edge.
  function automatic logic [ROW_W-1:0] step_row(input logic [ROW_W-1:0] row,
                                                input logic inc, input logic dec);
    logic [ROW_W-1:0] res;
    res = row;
    if (inc && !dec) begin
      res = (row == ROW_LAST) ? '0 : row + 1'b1;
    end else if (dec && !inc) begin
      res = (row == '0) ? ROW_LAST : row - 1'b1;
    end
    return res;
  endfunction

  function automatic logic [COL_W-1:0] step_col(input logic [COL_W-1:0] col,
                                                input logic inc, input logic dec);
    logic [COL_W-1:0] res;
    res = col;
    if (inc && !dec) begin
      res = (col == COL_LAST) ? '0 : col + 1'b1;
    end else if (dec && !inc) begin
      res = (col == '0) ? COL_LAST : col - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Per-button debounce with optional hold-to-repeat; emits a one-cycle event on an
// accepted press and on each repeat.
module btn_conditioner #(
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned RPT_DELAY = 32,
  parameter int unsigned RPT_RATE  = 8,
  parameter bit          RPT_EN    = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_evt
);

  localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(RPT_DELAY + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RPT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RPT_DELAY - RPT_RATE);

  logic              r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_evt;

  logic w_differs;
  logic w_accept;
  logic w_rpt;

  assign w_differs = (i_btn != r_state);
  assign w_accept  = i_tick && w_differs && (r_deb_cnt == DEB_LAST);
  // Held ticks only count while both the accepted state and the raw sample are high.
  assign w_rpt     = RPT_EN && i_tick && r_state && i_btn && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= 1'b0;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_evt      <= 1'b0;
    end else begin
      r_evt <= (w_accept && i_btn) || w_rpt;
      if (i_tick) begin
        if (!w_differs) begin
          r_deb_cnt <= '0;
        end else if (w_accept) begin
          r_deb_cnt <= '0;
          r_state   <= i_btn;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end

        if (!r_state || !i_btn || !RPT_EN) begin
          r_hold_cnt <= '0;
        end else if (w_rpt) begin
          r_hold_cnt <= HOLD_RELOAD;
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/cell_editor.sv
// Cursor-driven cell editor: conditions five buttons, moves a wrapping cursor and
// issues single-cell toggle writes over a valid/ready handshake.
module cell_editor
  import conway_pkg::*;
#(
  parameter int unsigned DEB_TICKS   = 4,
  parameter int unsigned RPT_DELAY   = 32,
  parameter int unsigned RPT_RATE    = 8,
  parameter int unsigned BLINK_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             edit_en,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_toggle,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  input  logic             cell_rd,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic             wr_data,
  output logic             cursor_blink
);

  localparam int unsigned BLK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] w_evt;

  editor_state_e    r_state;
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic             r_wr_valid;
  logic [ROW_W-1:0] r_wr_row;
  logic [COL_W-1:0] r_wr_col;
  logic             r_wr_data;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink;

  assign w_btn_raw = {btn_toggle, btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_conditioner #(
      .DEB_TICKS (DEB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE),
      .RPT_EN    (g != BTN_TOGGLE)
    ) u_cond (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_tick    (tick),
      .i_btn     (w_btn_raw[g]),
      .o_evt     (w_evt[g])
    );
  end

  // Events are honoured only in IDLE with editing enabled; anything else is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cur_row  <= CUR_ROW_RST;
      r_cur_col  <= CUR_COL_RST;
      r_wr_valid <= 1'b0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_data  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (edit_en) begin
            r_cur_row <= step_row(r_cur_row, w_evt[BTN_DOWN], w_evt[BTN_UP]);
            r_cur_col <= step_col(r_cur_col, w_evt[BTN_RIGHT], w_evt[BTN_LEFT]);
            if (w_evt[BTN_TOGGLE]) begin
              r_state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          r_wr_row   <= r_cur_row;
          r_wr_col   <= r_cur_col;
          r_wr_data  <= ~cell_rd;
          r_wr_valid <= 1'b1;
          r_state    <= WRITE;
        end
        WRITE: begin
          if (wr_ready) begin
            r_wr_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_wr_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (tick) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign cur_row      = r_cur_row;
  assign cur_col      = r_cur_col;
  assign wr_valid     = r_wr_valid;
  assign wr_row       = r_wr_row;
  assign wr_col       = r_wr_col;
  assign wr_data      = r_wr_data;
  assign cursor_blink = r_blink | ~edit_en;

endmodule

// File: tb/tb_cell_editor.sv
// Directed self-checking bench for cell_editor at default parameters.
module tb_cell_editor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       edit_en;
  logic       btn_up, btn_down, btn_left, btn_right, btn_toggle;
  logic [4:0] cur_row, cur_col;
  logic       cell_rd;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_row, wr_col;
  logic       wr_data;
  logic       cursor_blink;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] M_UP = 5'b00001, M_DOWN = 5'b00010, M_LEFT = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000, M_TOGGLE = 5'b10000;

  cell_editor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .edit_en      (edit_en),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_toggle   (btn_toggle),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .cell_rd      (cell_rd),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .cursor_blink (cursor_blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_toggle, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  // Each tick is followed by one idle cycle so the resulting event is applied.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic tap(input logic [4:0] m);
    set_btns(m);
    tick_n(4);
    set_btns(5'b0);
    tick_n(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    n_tests += 7;
    if (cur_row !== 5'd12) begin n_fail++; $display("FAIL rst_row: got %0d want 12", cur_row); end
    if (cur_col !== 5'd16) begin n_fail++; $display("FAIL rst_col: got %0d want 16", cur_col); end
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", wr_valid); end
    if (wr_row !== 5'd0) begin n_fail++; $display("FAIL rst_wr_row: got %0d want 0", wr_row); end
    if (wr_col !== 5'd0) begin n_fail++; $display("FAIL rst_wr_col: got %0d want 0", wr_col); end
    if (wr_data !== 1'b0) begin n_fail++; $display("FAIL rst_wr_data: got %b want 0", wr_data); end
    if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL rst_blink: got %b want 1", cursor_blink); end
  endtask

  task automatic test_blink();
    tick_n(15);
    n_tests++;
    if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL blink_15: got %b want 1", cursor_blink); end
    tick_n(1);
    n_tests++;
    if (cursor_blink !== 1'b0) begin n_fail++; $display("FAIL blink_16: got %b want 0", cursor_blink); end
    edit_en = 1'b0;
    #1;
    n_tests++;
    if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL blink_forced: got %b want 1", cursor_blink); end
    edit_en = 1'b1;
    #1;
  endtask

  task automatic test_debounce();
    set_btns(M_DOWN); tick_n(1);
    set_btns(5'b0);   tick_n(1);
    set_btns(M_DOWN); tick_n(3);
    n_tests++;
    if (cur_row !== 5'd12) begin n_fail++; $display("FAIL deb_early: got %0d want 12", cur_row); end
    tick_n(2);
    n_tests++;
    if (cur_row !== 5'd13) begin n_fail++; $display("FAIL deb_move: got %0d want 13", cur_row); end
    set_btns(5'b0); tick_n(4);
    n_tests++;
    if (cur_row !== 5'd13 || cur_col !== 5'd16) begin
      n_fail++; $display("FAIL deb_once: got (%0d,%0d) want (13,16)", cur_row, cur_col);
    end
    tap(M_UP);
    n_tests++;
    if (cur_row !== 5'd12) begin n_fail++; $display("FAIL deb_up: got %0d want 12", cur_row); end
  endtask

  task automatic test_repeat();
    set_btns(M_LEFT); tick_n(4);
    n_tests++;
    if (cur_col !== 5'd15) begin n_fail++; $display("FAIL rpt_press: got %0d want 15", cur_col); end
    tick_n(31);
    n_tests++;
    if (cur_col !== 5'd15) begin n_fail++; $display("FAIL rpt_t31: got %0d want 15", cur_col); end
    tick_n(1);
    n_tests++;
    if (cur_col !== 5'd14) begin n_fail++; $display("FAIL rpt_t32: got %0d want 14", cur_col); end
    tick_n(7);
    n_tests++;
    if (cur_col !== 5'd14) begin n_fail++; $display("FAIL rpt_t39: got %0d want 14", cur_col); end
    tick_n(1);
    n_tests++;
    if (cur_col !== 5'd13) begin n_fail++; $display("FAIL rpt_t40: got %0d want 13", cur_col); end
    tick_n(4);
    set_btns(5'b0); tick_n(4);
    n_tests++;
    if (cur_col !== 5'd13) begin n_fail++; $display("FAIL rpt_release: got %0d want 13", cur_col); end
    for (int i = 0; i < 13; i++) tap(M_LEFT);
    n_tests++;
    if (cur_col !== 5'd0) begin n_fail++; $display("FAIL rpt_col0: got %0d want 0", cur_col); end
    tap(M_LEFT);
    n_tests++;
    if (cur_col !== 5'd31) begin n_fail++; $display("FAIL wrap_left: got %0d want 31", cur_col); end
    tap(M_RIGHT);
    n_tests++;
    if (cur_col !== 5'd0) begin n_fail++; $display("FAIL wrap_right: got %0d want 0", cur_col); end
    for (int i = 0; i < 12; i++) tap(M_UP);
    n_tests++;
    if (cur_row !== 5'd0) begin n_fail++; $display("FAIL row0: got %0d want 0", cur_row); end
    tap(M_UP);
    n_tests++;
    if (cur_row !== 5'd23) begin n_fail++; $display("FAIL wrap_up: got %0d want 23", cur_row); end
    tap(M_DOWN);
    n_tests++;
    if (cur_row !== 5'd0) begin n_fail++; $display("FAIL wrap_down: got %0d want 0", cur_row); end
    for (int i = 0; i < 12; i++) tap(M_DOWN);
    for (int i = 0; i < 16; i++) tap(M_RIGHT);
    n_tests++;
    if (cur_row !== 5'd12 || cur_col !== 5'd16) begin
      n_fail++; $display("FAIL rpt_home: got (%0d,%0d) want (12,16)", cur_row, cur_col);
    end
  endtask

  task automatic test_diag();
    tap(M_UP | M_DOWN | M_RIGHT);
    n_tests++;
    if (cur_row !== 5'd12 || cur_col !== 5'd17) begin
      n_fail++; $display("FAIL diag_cancel: got (%0d,%0d) want (12,17)", cur_row, cur_col);
    end
    tap(M_DOWN | M_LEFT);
    n_tests++;
    if (cur_row !== 5'd13 || cur_col !== 5'd16) begin
      n_fail++; $display("FAIL diag_move: got (%0d,%0d) want (13,16)", cur_row, cur_col);
    end
    tap(M_UP);
  endtask

  task automatic test_write();
    cell_rd  = 1'b0;
    wr_ready = 1'b0;
    set_btns(M_TOGGLE); tick_n(4);
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_latency: got %b want 0", wr_valid); end
    step();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (wr_valid !== 1'b1 || wr_row !== 5'd12 || wr_col !== 5'd16 || wr_data !== 1'b1) begin
        n_fail++;
        $display("FAIL wr_hold%0d: got v%b (%0d,%0d) d%b want v1 (12,16) d1",
                 i, wr_valid, wr_row, wr_col, wr_data);
      end
      step();
    end
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_done: got %b want 0", wr_valid); end
    set_btns(5'b0); tick_n(4);
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_single: got %b want 0", wr_valid); end
  endtask

  task automatic test_edit_en();
    edit_en = 1'b0;
    tap(M_TOGGLE);
    tap(M_DOWN);
    repeat (3) step();
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_wr: got %b want 0", wr_valid); end
    n_tests++;
    if (cur_row !== 5'd12) begin n_fail++; $display("FAIL en_off_move: got %0d want 12", cur_row); end
    edit_en = 1'b1;
    cell_rd = 1'b1;
    set_btns(M_TOGGLE); tick_n(4);
    step();
    n_tests++;
    if (wr_valid !== 1'b1 || wr_data !== 1'b0) begin
      n_fail++; $display("FAIL en_wr_start: got v%b d%b want v1 d0", wr_valid, wr_data);
    end
    edit_en = 1'b0;
    repeat (2) step();
    n_tests++;
    if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL en_drop_hold: got %b want 1", wr_valid); end
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_done: got %b want 0", wr_valid); end
    edit_en = 1'b1;
    cell_rd = 1'b0;
    set_btns(5'b0); tick_n(4);
  endtask

  task automatic test_reset_mid_write();
    tap(M_RIGHT);
    set_btns(M_TOGGLE); tick_n(4);
    step();
    n_tests++;
    if (wr_valid !== 1'b1 || wr_col !== 5'd17) begin
      n_fail++; $display("FAIL rmw_start: got v%b col%0d want v1 col17", wr_valid, wr_col);
    end
    set_btns(5'b0);
    reset_n = 1'b0;
    step();
    n_tests++;
    if (wr_valid !== 1'b0 || cur_row !== 5'd12 || cur_col !== 5'd16 || wr_col !== 5'd0) begin
      n_fail++;
      $display("FAIL rmw_reset: got v%b (%0d,%0d) wcol%0d want v0 (12,16) wcol0",
               wr_valid, cur_row, cur_col, wr_col);
    end
    reset_n = 1'b1;
    wr_ready = 1'b1;
    repeat (3) step();
    wr_ready = 1'b0;
    n_tests++;
    if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_abandon: got %b want 0", wr_valid); end
  endtask

  initial begin
    reset_n  = 1'b0;
    tick     = 1'b0;
    edit_en  = 1'b1;
    cell_rd  = 1'b0;
    wr_ready = 1'b0;
    set_btns(5'b0);
    test_reset();
    test_blink();
    test_debounce();
    test_repeat();
    test_diag();
    test_write();
    test_edit_en();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
